// File: rtl/request_buffer.sv
// Two-channel request feeder for the two-client arbiter: counts request pulses per client,
// holds a level request until SERVICE consecutive grant cycles retire one entry.
module request_buffer #(
    parameter int DEPTH   = 4,
    parameter int SERVICE = 2,
    parameter int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push0,
    input  logic          push1,
    input  logic          g0,
    input  logic          g1,
    output logic          r0,
    output logic          r1,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1,
    output logic          full0,
    output logic          full1,
    output logic          done0,
    output logic          done1,
    output logic          ovf0,
    output logic          ovf1,
    output logic          proto_err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVE,
        ST_RELEASE
    } state_t;

    localparam int            TW         = (SERVICE > 1) ? $clog2(SERVICE) : 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SERVICE - 1);

    logic [1:0]      w_push;
    logic [1:0]      w_g;
    logic [1:0]      w_req;
    logic [1:0]      w_done;
    logic [1:0]      w_full;
    logic [1:0]      w_ovf;
    logic [2*CW-1:0] w_cnt_all;
    logic            w_proto;
    logic            r_proto_err;

    assign w_push = {push1, push0};
    assign w_g    = {g1, g0};

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        state_t        r_state;
        state_t        w_state_nxt;
        logic [CW-1:0] r_cnt;
        logic [CW-1:0] w_cnt_nxt;
        logic [TW-1:0] r_timer;
        logic [TW-1:0] w_timer_nxt;
        logic          r_ovf;
        logic          w_retire;
        logic          w_accept;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_timer <= '0;
                r_ovf   <= 1'b0;
            end else begin
                r_state <= w_state_nxt;
                r_cnt   <= w_cnt_nxt;
                r_timer <= w_timer_nxt;
                if (w_push[gi] && !w_accept) begin
                    r_ovf <= 1'b1;
                end
            end
        end

        // Grants seen outside REQ/SERVE never move the FSM; they only raise proto_err.
        always_comb begin
            w_state_nxt = r_state;
            w_timer_nxt = r_timer;
            w_retire    = 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_cnt != '0 || w_push[gi]) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (w_g[gi]) begin
                        if (SERVICE == 1) begin
                            w_retire    = 1'b1;
                            w_state_nxt = ST_RELEASE;
                        end else begin
                            w_state_nxt = ST_SERVE;
                            w_timer_nxt = TW'(1);
                        end
                    end
                end
                ST_SERVE: begin
                    if (!w_g[gi]) begin
                        w_state_nxt = ST_REQ;
                        w_timer_nxt = '0;
                    end else if (r_timer == TIMER_LAST) begin
                        w_retire    = 1'b1;
                        w_state_nxt = ST_RELEASE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                ST_RELEASE: begin
                    w_state_nxt = (r_cnt != '0 || w_push[gi]) ? ST_REQ : ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
            w_retire  = w_retire && (r_cnt != '0);
            w_accept  = w_push[gi] && ((r_cnt != CNT_MAX) || w_retire);
            w_cnt_nxt = r_cnt + CW'(w_accept) - CW'(w_retire);
        end

        assign w_req[gi]                 = (r_state == ST_REQ) || (r_state == ST_SERVE);
        assign w_done[gi]                = (r_state == ST_RELEASE);
        assign w_full[gi]                = (r_cnt == CNT_MAX);
        assign w_ovf[gi]                 = r_ovf;
        assign w_cnt_all[gi*CW +: CW]    = r_cnt;
    end

    assign w_proto = (g0 && !r0) || (g1 && !r1) || (g0 && g1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_proto_err <= 1'b0;
        end else if (w_proto) begin
            r_proto_err <= 1'b1;
        end
    end

    assign r0        = w_req[0];
    assign r1        = w_req[1];
    assign done0     = w_done[0];
    assign done1     = w_done[1];
    assign full0     = w_full[0];
    assign full1     = w_full[1];
    assign ovf0      = w_ovf[0];
    assign ovf1      = w_ovf[1];
    assign cnt0      = w_cnt_all[CW-1:0];
    assign cnt1      = w_cnt_all[2*CW-1:CW];
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_request_buffer.sv
// Scenario bench for request_buffer: each task queues the per-cycle expected outputs
// derived from the behavioural timeline, then drives stimulus and pops/compares.
module tb_request_buffer;

    localparam int DEPTH   = 4;
    localparam int SERVICE = 2;
    localparam int CW      = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          push0 = 1'b0;
    logic          push1 = 1'b0;
    logic          g0    = 1'b0;
    logic          g1    = 1'b0;
    logic          r0, r1, full0, full1, done0, done1, ovf0, ovf1, proto_err;
    logic [CW-1:0] cnt0, cnt1;

    logic [14:0] obs;
    logic [14:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    localparam logic [6:0] CH_IDLE = 7'b0;

    always #5 clock = ~clock;

    request_buffer #(.DEPTH(DEPTH), .SERVICE(SERVICE)) dut (
        .clock(clock), .reset(reset), .push0(push0), .push1(push1), .g0(g0), .g1(g1),
        .r0(r0), .r1(r1), .cnt0(cnt0), .cnt1(cnt1), .full0(full0), .full1(full1),
        .done0(done0), .done1(done1), .ovf0(ovf0), .ovf1(ovf1), .proto_err(proto_err)
    );

    assign obs = {proto_err, r1, done1, cnt1, full1, ovf1, r0, done0, cnt0, full0, ovf0};

    function automatic logic [6:0] ch(input logic r, input logic d, input int c,
                                      input logic f, input logic o);
        return {r, d, CW'(c), f, o};
    endfunction

    function automatic logic [14:0] ev(input logic p, input logic [6:0] c1, input logic [6:0] c0);
        return {p, c1, c0};
    endfunction

    // Inputs apply at the next rising edge; outputs are sampled 1ns after it.
    task automatic cycle(input logic p0, input logic p1, input logic a0, input logic a1);
        push0 = p0;
        push1 = p1;
        g0    = a0;
        g1    = a1;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        push0 = 1'b0; push1 = 1'b0; g0 = 1'b0; g1 = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [14:0] want;
        reset = 1'b1;
        @(posedge clock);
        #1;
        want = '0;
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL reset_held: got %h want %h", obs, want);
        end
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL reset_idle: got %h want %h", obs, want);
        end
    endtask

    task automatic test_single;
        logic [3:0]  stim [4];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1000, 4'b0010, 4'b0010, 4'b0000};
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(0, 1, 0, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, CH_IDLE));
        for (int i = 0; i < 4; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL single step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_overflow;
        logic [14:0] got, want;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, (k > DEPTH) ? DEPTH : k, k >= DEPTH, k > DEPTH)));
        end
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, DEPTH, 1, 1)));
        for (int i = 0; i < 6; i++) begin
            cycle(i < 5, 0, 0, 0);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL overflow step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_preempt;
        logic [3:0]  stim [6];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1000, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        end
        exp_q.push_back(ev(0, CH_IDLE, ch(0, 1, 0, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, CH_IDLE));
        for (int i = 0; i < 6; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL preempt step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_full_retire;
        logic [3:0]  stim [7];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b1010, 4'b0000};
        for (int k = 1; k <= DEPTH; k++) begin
            exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, k, k == DEPTH, 0)));
        end
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, DEPTH, 1, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(0, 1, DEPTH, 1, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, DEPTH, 1, 0)));
        for (int i = 0; i < 7; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL full_retire step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_held_grant;
        logic [3:0]  stim [8];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1000, 4'b1000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 2, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 2, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(0, 1, 1, 0, 0)));
        exp_q.push_back(ev(1, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(1, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(1, CH_IDLE, ch(0, 1, 0, 0, 0)));
        exp_q.push_back(ev(1, CH_IDLE, CH_IDLE));
        for (int i = 0; i < 8; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL held_grant step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  stim [5];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1000, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(0, 1, 0, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(0, CH_IDLE, ch(1, 0, 1, 0, 0)));
        for (int i = 0; i < 5; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL back_to_back step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_dual_grant;
        logic [3:0]  stim [4];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b1100, 4'b0011, 4'b0011, 4'b0000};
        exp_q.push_back(ev(0, ch(1, 0, 1, 0, 0), ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(1, ch(1, 0, 1, 0, 0), ch(1, 0, 1, 0, 0)));
        exp_q.push_back(ev(1, ch(0, 1, 0, 0, 0), ch(0, 1, 0, 0, 0)));
        exp_q.push_back(ev(1, CH_IDLE, CH_IDLE));
        for (int i = 0; i < 4; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL dual_grant step %0d: got %h want %h", i, got, want);
            end
        end
    endtask

    task automatic test_overflow_random;
        int          n;
        logic [14:0] got, want;
        do_reset();
        n = $urandom_range(1, DEPTH + 3);
        for (int k = 1; k <= n; k++) begin
            exp_q.push_back(ev(0, ch(1, 0, (k > DEPTH) ? DEPTH : k, k >= DEPTH, k > DEPTH), CH_IDLE));
        end
        exp_q.push_back(ev(0, ch(1, 0, (n > DEPTH) ? DEPTH : n, n >= DEPTH, n > DEPTH), CH_IDLE));
        for (int i = 0; i <= n; i++) begin
            cycle(0, i < n, 0, 0);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL ovf_random n=%0d step %0d: got %h want %h", n, i, got, want);
            end
        end
    endtask

    task automatic test_proto_reset;
        logic [3:0]  stim [4];
        logic [14:0] got, want;
        do_reset();
        stim = '{4'b0001, 4'b0000, 4'b0100, 4'b0001};
        exp_q.push_back(ev(1, CH_IDLE, CH_IDLE));
        exp_q.push_back(ev(1, CH_IDLE, CH_IDLE));
        exp_q.push_back(ev(1, ch(1, 0, 1, 0, 0), CH_IDLE));
        exp_q.push_back(ev(1, ch(1, 0, 1, 0, 0), CH_IDLE));
        for (int i = 0; i < 4; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            got = obs; want = exp_q.pop_front(); n_checks++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL proto_reset step %0d: got %h want %h", i, got, want);
            end
        end
        // Channel 1 is mid-SERVE here; reset must clear outputs without a clock edge.
        g1    = 1'b0;
        reset = 1'b1;
        #2;
        want = '0;
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs, want);
        end
        #1;
        reset = 1'b0;
        cycle(0, 0, 0, 0);
        n_checks++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL after_async_reset: got %h want %h", obs, want);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_preempt();
        test_full_retire();
        test_held_grant();
        test_back_to_back();
        test_dual_grant();
        test_overflow_random();
        test_proto_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
